// File: rtl/neural_pkg.sv
// Shared constants, state encoding and registered-output bundle for the inference sequencer.
package neural_pkg;

  localparam int NUM_L1_GROUPS = 3;
  localparam int GROUP_W       = 10;
  localparam int REG_LOAD_W    = 30;
  localparam int SEL_W         = 2;

  localparam logic [SEL_W-1:0]      L2_BANK    = 2'd3;
  localparam logic [REG_LOAD_W-1:0] GROUP_ONES = REG_LOAD_W'((1 << GROUP_W) - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_L1,
    ST_L2,
    ST_CMP,
    ST_NEXT,
    ST_DONE
  } seq_state_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  label_mem_read;
    logic                  input_sel;
    logic                  reg_sel;
    logic [SEL_W-1:0]      weight_sel;
    logic [SEL_W-1:0]      bias_sel;
    logic [REG_LOAD_W-1:0] reg_load;
    logic                  addr_count_enable;
    logic                  cmp_phase;
    logic                  busy;
    logic                  done;
  } seq_out_t;

endpackage

// File: rtl/seq_counter.sv
// Up-counter with synchronous clear; used for both the pass index and the sample index.
module seq_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst)     count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/inference_sequencer.sv
// Batch sequencer for a two-layer inference datapath: fetch, layer-1 passes, layer-2, compare, advance.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | read sample and label memories
// L1    | layer-1 pass pass_idx, loads 10 hidden registers
// L2    | layer-2 evaluation
// CMP   | accuracy counter increments when eql
// NEXT  | advance address counter and sample index
// DONE  | batch complete, waiting for start
module inference_sequencer
  import neural_pkg::*;
#(
  parameter int SAMPLE_W  = 10,
  parameter int L1_GROUPS = NUM_L1_GROUPS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SAMPLE_W-1:0]   num_samples,
  input  logic                  eql,
  output logic                  mem_read,
  output logic                  label_mem_read,
  output logic                  input_sel,
  output logic                  reg_sel,
  output logic [SEL_W-1:0]      weight_sel,
  output logic [SEL_W-1:0]      bias_sel,
  output logic [REG_LOAD_W-1:0] reg_load,
  output logic                  addr_count_enable,
  output logic                  ac_count_enable,
  output logic                  busy,
  output logic                  done
);

  seq_state_t            state, next_state;
  seq_out_t              out_d, out_q;
  logic [SEL_W-1:0]      pass_idx;
  logic [SAMPLE_W-1:0]   sample_idx, num_q;
  logic                  pass_clr, pass_inc, samp_clr, samp_inc, num_load;

  seq_counter #(.W(SEL_W)) u_pass (
    .clk(clk), .rst(rst), .clr(pass_clr), .inc(pass_inc), .count(pass_idx)
  );

  seq_counter #(.W(SAMPLE_W)) u_sample (
    .clk(clk), .rst(rst), .clr(samp_clr), .inc(samp_inc), .count(sample_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      num_q <= '0;
      out_q <= '0;
    end else begin
      if (num_load) num_q <= num_samples;
      out_q <= out_d;
    end
  end

  always_comb begin
    next_state = state;
    out_d      = '0;
    pass_clr   = 1'b0;
    pass_inc   = 1'b0;
    samp_clr   = 1'b0;
    samp_inc   = 1'b0;
    num_load   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        out_d.done = (state == ST_DONE) && !start;
        if (start) begin
          num_load   = 1'b1;
          samp_clr   = 1'b1;
          pass_clr   = 1'b1;
          next_state = (num_samples == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        out_d.mem_read       = 1'b1;
        out_d.label_mem_read = 1'b1;
        out_d.busy           = 1'b1;
        pass_clr             = 1'b1;
        next_state           = ST_L1;
      end
      ST_L1: begin
        out_d.busy       = 1'b1;
        out_d.weight_sel = pass_idx;
        out_d.bias_sel   = pass_idx;
        out_d.reg_load   = GROUP_ONES << (GROUP_W * int'(pass_idx));
        if (pass_idx == SEL_W'(L1_GROUPS - 1)) begin
          pass_clr   = 1'b1;
          next_state = ST_L2;
        end else begin
          pass_inc = 1'b1;
        end
      end
      ST_L2: begin
        out_d.busy       = 1'b1;
        out_d.input_sel  = 1'b1;
        out_d.reg_sel    = 1'b1;
        out_d.weight_sel = L2_BANK;
        out_d.bias_sel   = L2_BANK;
        next_state       = ST_CMP;
      end
      ST_CMP: begin
        out_d.busy      = 1'b1;
        out_d.cmp_phase = 1'b1;
        next_state      = ST_NEXT;
      end
      ST_NEXT: begin
        out_d.busy              = 1'b1;
        out_d.addr_count_enable = 1'b1;
        samp_inc                = 1'b1;
        next_state = (sample_idx == num_q - SAMPLE_W'(1)) ? ST_DONE : ST_LOAD;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign mem_read          = out_q.mem_read;
  assign label_mem_read    = out_q.label_mem_read;
  assign input_sel         = out_q.input_sel;
  assign reg_sel           = out_q.reg_sel;
  assign weight_sel        = out_q.weight_sel;
  assign bias_sel          = out_q.bias_sel;
  assign reg_load          = out_q.reg_load;
  assign addr_count_enable = out_q.addr_count_enable;
  assign ac_count_enable   = out_q.cmp_phase & eql;
  assign busy              = out_q.busy;
  assign done              = out_q.done;

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_W, 10, sample-index and sample-count width.
REQ-002 SHALL have parameter L1_GROUPS, 3, hidden-layer passes per sample; each pass covers 10 neurons.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  begin a batch; sampled only in IDLE or DONE.
REQ-006 SHALL have port num_samples  input  SAMPLE_W  batch length; latched on an accepted start.
REQ-007 SHALL have port eql  input  1  datapath "predicted equals label" flag.
REQ-008 SHALL have port mem_read, label_mem_read  output  1 each  data and label memory read strobes.
REQ-009 SHALL have port input_sel, reg_sel  output  1 each  datapath operand selects: 0 = layer 1, 1 = layer 2.
REQ-010 SHALL have port weight_sel, bias_sel  output  2 each  weight/bias bank select.
REQ-011 SHALL have port reg_load  output  30  hidden-register load enables.
REQ-012 SHALL have port addr_count_enable, ac_count_enable  output  1 each  address-counter and accuracy-counter increments.
REQ-013 SHALL have port busy, done  output  1 each  batch in progress / batch complete.

Function
REQ-014 SHALL implement the states IDLE, LOAD, L1, L2, CMP, NEXT and DONE.
REQ-015 IDLE or DONE with start=1 SHALL go to LOAD, latch num_samples, clear sample_idx and clear done.
REQ-016 If the latched num_samples is 0, the block SHALL go directly to DONE on the next cycle with no datapath strobes.
REQ-017 LOAD SHALL assert mem_read=1 and label_mem_read=1 for exactly 1 cycle, then go to L1 with pass_idx=0.
REQ-018 L1 at pass g SHALL drive input_sel=0, reg_sel=0, weight_sel=g, bias_sel=g and reg_load[10g+9:10g]=all-ones, with all other reg_load bits 0.
REQ-019 L1 SHALL increment pass_idx each cycle and SHALL go to L2 after pass L1_GROUPS-1.
REQ-020 L2 SHALL drive input_sel=1, reg_sel=1, weight_sel=3, bias_sel=3 and reg_load=0 for 1 cycle, then go to CMP.
REQ-021 CMP SHALL drive ac_count_enable=eql for 1 cycle, then go to NEXT.
REQ-022 NEXT SHALL assert addr_count_enable=1 for 1 cycle and increment sample_idx.
REQ-023 From NEXT, if sample_idx == num_samples-1 the block SHALL go to DONE; otherwise it SHALL go to LOAD.
REQ-024 DONE SHALL hold done=1 and busy=0 until an accepted start.
REQ-025 busy SHALL be 1 in every state except IDLE and DONE.
REQ-026 start asserted while busy=1 SHALL be ignored.
REQ-027 num_samples changing while busy=1 SHALL have no effect.
REQ-028 All strobes not named for the current state SHALL be 0, and selects SHALL be 0.
REQ-029 Per-sample latency SHALL be 4+L1_GROUPS cycles (7 at the default); a batch of N samples SHALL assert done exactly 7N+1 cycles after the accepted start edge.
REQ-030 sample_idx SHALL NOT wrap; num_samples = 2^SAMPLE_W-1 SHALL complete normally.
REQ-031 All outputs SHALL be registered Moore outputs decoded from state/pass_idx, except ac_count_enable, which follows eql combinationally in CMP.

Reset
REQ-032 rst=0 at a clock edge SHALL force IDLE, pass_idx=0, sample_idx=0 and the latched count to 0.
REQ-033 Reset SHALL drive every output to 0, including done and busy.
REQ-034 Reset asserted mid-batch SHALL abort the batch within the same edge, with no further strobes.

Structure
REQ-035 State encoding, L1_GROUPS, the 10-neuron group width, the 30-bit reg_load width and the layer-2 bank index 3 SHALL live in shared package neural_pkg.
REQ-036 The FSM and output decode SHALL be in this module; the pass/sample counters SHALL be one sub-module, seq_counter, instantiated twice.

Verification
REQ-037 Reset then start with num_samples=1 -> mem_read pulses at cycle 1, reg_load = 0x00003FF, 0x00FFC00, 0x3FF00000 on cycles 2-4, L2 on cycle 5, done=1 at cycle 8.
REQ-038 num_samples=3 with eql held 1 -> 3 ac_count_enable pulses, 3 addr_count_enable pulses, done after 22 cycles.
REQ-039 num_samples=0 -> done=1 one cycle after start, with zero mem_read/addr_count_enable pulses.
REQ-040 start pulsed repeatedly during busy -> ignored: the pulse count for num_samples=2 is unchanged and done occurs at cycle 15.
REQ-041 rst=0 during L1 pass 1 -> next cycle all outputs 0 and state IDLE; a later start runs a full batch correctly.
REQ-042 Alternating eql across num_samples=4 -> ac_count_enable pulses only in CMP cycles where eql=1 (2 pulses).
